// File: rtl/winograd_pkg.sv
// Shared constants, FSM state type and flattened-tile layout for the Winograd
// F(2x2,3x3) input path (feeder, PE and output collector).
package winograd_pkg;

    localparam int unsigned INPUT_TILE_SIZE = 4;
    localparam int unsigned KERNEL_SIZE     = 3;
    localparam int unsigned WINO_STRIDE     = INPUT_TILE_SIZE - KERNEL_SIZE + 1;
    localparam int unsigned TILE_ELEMS      = INPUT_TILE_SIZE ** 2;
    localparam int unsigned ROW_SLOTS       = 4;

    typedef enum logic {FILL, EMIT} feeder_state_e;

    // Bit offset of tile element (row i, col j, channel k); channel planes are outermost.
    function automatic int unsigned tile_bit_offset(input int unsigned i, input int unsigned j,
                                                    input int unsigned k,
                                                    input int unsigned data_width);
        return ((INPUT_TILE_SIZE * i + j) + TILE_ELEMS * k) * data_width;
    endfunction

endpackage

// File: rtl/winograd_tile_feeder_if.sv
// Pixel-in / tile-out bundle of the Winograd tile feeder.
interface winograd_tile_feeder_if #(
    parameter int unsigned IMG_WIDTH        = 8,
    parameter int unsigned IMG_HEIGHT       = 8,
    parameter int unsigned INPUT_DATA_WIDTH = 8,
    parameter int unsigned CHANNELS         = 3
);
    import winograd_pkg::*;

    localparam int unsigned PIXEL_W   = CHANNELS * INPUT_DATA_WIDTH;
    localparam int unsigned TILE_W    = TILE_ELEMS * PIXEL_W;
    localparam int unsigned NTR       = (IMG_HEIGHT - WINO_STRIDE) / WINO_STRIDE;
    localparam int unsigned NTC       = (IMG_WIDTH - WINO_STRIDE) / WINO_STRIDE;
    localparam int unsigned ROW_IDX_W = (NTR > 1) ? $clog2(NTR) : 1;
    localparam int unsigned COL_IDX_W = (NTC > 1) ? $clog2(NTC) : 1;

    logic                 s_valid;
    logic                 s_ready;
    logic [PIXEL_W-1:0]   s_pixel;
    logic                 m_valid;
    logic                 m_ready;
    logic [TILE_W-1:0]    m_tile;
    logic [ROW_IDX_W-1:0] m_tile_row;
    logic [COL_IDX_W-1:0] m_tile_col;
    logic                 m_last;
    logic                 frame_done;

    modport master (
        input  s_valid, s_pixel, m_ready,
        output s_ready, m_valid, m_tile, m_tile_row, m_tile_col, m_last, frame_done
    );

    modport slave (
        output s_valid, s_pixel, m_ready,
        input  s_ready, m_valid, m_tile, m_tile_row, m_tile_col, m_last, frame_done
    );

endinterface

// File: rtl/tile_row_buffer.sv
// Four-slot circular row store with a combinational 4x4 window read that
// forwards a same-cycle write, so the final pixel of a fill is visible at once.
module tile_row_buffer
    import winograd_pkg::*;
#(
    parameter int unsigned IMG_WIDTH = 8,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned CHANNELS  = 3,
    localparam int unsigned PIXEL_W  = CHANNELS * DATA_W,
    localparam int unsigned TILE_W   = TILE_ELEMS * PIXEL_W,
    localparam int unsigned COL_W    = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [1:0]         wr_slot,
    input  logic [COL_W-1:0]   wr_col,
    input  logic [PIXEL_W-1:0] wr_pixel,
    input  logic [1:0]         rd_base,
    input  logic [COL_W-1:0]   rd_col,
    output logic [TILE_W-1:0]  window_c
);

    logic [PIXEL_W-1:0] mem [ROW_SLOTS][IMG_WIDTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_slot][wr_col] <= wr_pixel;
        end
    end

    always_comb begin
        window_c = '0;
        for (int i = 0; i < INPUT_TILE_SIZE; i++) begin
            for (int j = 0; j < INPUT_TILE_SIZE; j++) begin : g_elem
                logic [1:0]         slot;
                logic [COL_W-1:0]   col;
                logic [PIXEL_W-1:0] pix;
                slot = rd_base + 2'(i);
                col  = rd_col + COL_W'(j);
                pix  = (wr_en && wr_slot == slot && wr_col == col) ? wr_pixel : mem[slot][col];
                for (int k = 0; k < CHANNELS; k++) begin
                    window_c[tile_bit_offset(i, j, k, DATA_W) +: DATA_W] = pix[k*DATA_W +: DATA_W];
                end
            end
        end
    end

endmodule

// File: rtl/winograd_tile_feeder.sv
// Raster pixel stream in, overlapping stride-2 4x4xC Winograd input tiles out;
// alternates between filling rows and emitting one tile row.
module winograd_tile_feeder
    import winograd_pkg::*;
#(
    parameter int unsigned IMG_WIDTH        = 8,
    parameter int unsigned IMG_HEIGHT       = 8,
    parameter int unsigned INPUT_DATA_WIDTH = 8,
    parameter int unsigned CHANNELS         = 3
) (
    input logic                   clk,
    input logic                   reset,
    winograd_tile_feeder_if.master bus
);

    localparam int unsigned TILE_W    = TILE_ELEMS * CHANNELS * INPUT_DATA_WIDTH;
    localparam int unsigned NTR       = (IMG_HEIGHT - WINO_STRIDE) / WINO_STRIDE;
    localparam int unsigned NTC       = (IMG_WIDTH - WINO_STRIDE) / WINO_STRIDE;
    localparam int unsigned COL_W     = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int unsigned ROW_IDX_W = (NTR > 1) ? $clog2(NTR) : 1;
    localparam int unsigned COL_IDX_W = (NTC > 1) ? $clog2(NTC) : 1;

    feeder_state_e        state, state_d;
    logic [COL_W-1:0]     col_cnt, col_cnt_d;
    logic [1:0]           row_fill, row_fill_d;
    logic [1:0]           base, base_d;
    logic [ROW_IDX_W-1:0] tr, tr_d;
    logic [COL_IDX_W-1:0] tc, tc_d;
    logic                 m_valid_q, m_valid_d;
    logic [TILE_W-1:0]    m_tile_q, m_tile_d;
    logic                 m_last_q, m_last_d;
    logic                 frame_done_q, frame_done_d;

    logic                 accept_c;
    logic                 handshake_c;
    logic                 last_pixel_c;
    logic                 last_row_c;
    logic [COL_W-1:0]     rd_col_c;
    logic [TILE_W-1:0]    window_c;

    assign bus.s_ready  = (state == FILL) && !reset;
    assign accept_c     = bus.s_valid && bus.s_ready;
    assign handshake_c  = m_valid_q && bus.m_ready;
    assign last_pixel_c = (row_fill == 2'd3) && (col_cnt == COL_W'(IMG_WIDTH - 1));
    assign last_row_c   = (tr == ROW_IDX_W'(NTR - 1));

    // Window column: tile 0 while filling, the next tile column while emitting.
    assign rd_col_c = (state == EMIT && tc != COL_IDX_W'(NTC - 1))
                    ? COL_W'(WINO_STRIDE * (32'(tc) + 32'd1)) : '0;

    tile_row_buffer #(
        .IMG_WIDTH (IMG_WIDTH),
        .DATA_W    (INPUT_DATA_WIDTH),
        .CHANNELS  (CHANNELS)
    ) u_rows (
        .clk      (clk),
        .wr_en    (accept_c),
        .wr_slot  (base + row_fill),
        .wr_col   (col_cnt),
        .wr_pixel (bus.s_pixel),
        .rd_base  (base),
        .rd_col   (rd_col_c),
        .window_c (window_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= FILL;
            col_cnt      <= '0;
            row_fill     <= '0;
            base         <= '0;
            tr           <= '0;
            tc           <= '0;
            m_valid_q    <= 1'b0;
            m_tile_q     <= '0;
            m_last_q     <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state        <= state_d;
            col_cnt      <= col_cnt_d;
            row_fill     <= row_fill_d;
            base         <= base_d;
            tr           <= tr_d;
            tc           <= tc_d;
            m_valid_q    <= m_valid_d;
            m_tile_q     <= m_tile_d;
            m_last_q     <= m_last_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        state_d      = state;
        col_cnt_d    = col_cnt;
        row_fill_d   = row_fill;
        base_d       = base;
        tr_d         = tr;
        tc_d         = tc;
        m_valid_d    = m_valid_q;
        m_tile_d     = m_tile_q;
        m_last_d     = m_last_q;
        frame_done_d = 1'b0;
        case (state)
            FILL: begin
                if (accept_c) begin
                    if (last_pixel_c) begin
                        state_d   = EMIT;
                        col_cnt_d = '0;
                        tc_d      = '0;
                        m_valid_d = 1'b1;
                        m_tile_d  = window_c;
                        m_last_d  = last_row_c && (NTC == 1);
                    end else if (col_cnt == COL_W'(IMG_WIDTH - 1)) begin
                        col_cnt_d  = '0;
                        row_fill_d = row_fill + 2'd1;
                    end else begin
                        col_cnt_d = col_cnt + 1'b1;
                    end
                end
            end
            EMIT: begin
                if (handshake_c) begin
                    if (tc != COL_IDX_W'(NTC - 1)) begin
                        tc_d     = tc + 1'b1;
                        m_tile_d = window_c;
                        m_last_d = last_row_c && (tc + 1'b1 == COL_IDX_W'(NTC - 1));
                    end else begin
                        state_d   = FILL;
                        m_valid_d = 1'b0;
                        m_last_d  = 1'b0;
                        tc_d      = '0;
                        // Later tile rows only need the two rows below the current window.
                        if (!last_row_c) begin
                            tr_d       = tr + 1'b1;
                            base_d     = base + 2'd2;
                            row_fill_d = 2'd2;
                        end else begin
                            tr_d         = '0;
                            base_d       = '0;
                            row_fill_d   = '0;
                            frame_done_d = 1'b1;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    assign bus.m_valid    = m_valid_q;
    assign bus.m_tile     = m_tile_q;
    assign bus.m_tile_row = tr;
    assign bus.m_tile_col = tc;
    assign bus.m_last     = m_last_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_winograd_tile_feeder.sv
// Scoreboard bench for winograd_tile_feeder on an 8x8x3 image with
// sample(r,c,k) = r*8 + c + 64*k (+1 for the offset frame).
module tb_winograd_tile_feeder;

    localparam int unsigned W      = 8;
    localparam int unsigned H      = 8;
    localparam int unsigned DW     = 8;
    localparam int unsigned C      = 3;
    localparam int unsigned TILE_W = 16 * DW * C;

    typedef struct {
        logic [TILE_W-1:0] tile;
        int                row;
        int                col;
        bit                last;
        int                off;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    winograd_tile_feeder_if #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .INPUT_DATA_WIDTH(DW), .CHANNELS(C)) bus ();

    winograd_tile_feeder #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .INPUT_DATA_WIDTH(DW), .CHANNELS(C)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int   checks = 0;
    int   errors = 0;
    int   fd_count = 0;
    int   cyc = 0;
    exp_t sb[$];

    function automatic logic [7:0] sample(input int r, input int c, input int k, input int off);
        return 8'(r * 8 + c + 64 * k + off);
    endfunction

    function automatic logic [TILE_W-1:0] model_tile(input int tr, input int tc, input int off);
        logic [TILE_W-1:0] t;
        t = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                for (int k = 0; k < 3; k++)
                    t[((4 * i + j) + 16 * k) * DW +: DW] = sample(2 * tr + i, 2 * tc + j, k, off);
        return t;
    endfunction

    function automatic int elem(input logic [TILE_W-1:0] t, input int i, input int j, input int k);
        return int'(t[((4 * i + j) + 16 * k) * DW +: DW]);
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic check_tile(input string name, input logic [TILE_W-1:0] act, input logic [TILE_W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic push_frame(input int off);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                sb.push_back('{model_tile(r, c, off), r, c, (r == 2 && c == 2), off});
    endtask

    task automatic bail(input string what);
        errors++;
        $display("FAIL %s: bound expired at t=%0t", what, $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "bench stopped");
    endtask

    // Called in the posedge+1 phase; returns early once tile (ar,ac) is presented.
    task automatic feed_frame(input int off, input bit bub, input int ar, input int ac);
        for (int r = 0; r < int'(H); r++) begin
            for (int c = 0; c < int'(W); c++) begin
                bit done;
                int guard;
                done  = 1'b0;
                guard = 0;
                while (!done) begin
                    bus.s_valid = bub ? 1'($urandom_range(0, 1)) : 1'b1;
                    bus.s_pixel = {sample(r, c, 2, off), sample(r, c, 1, off), sample(r, c, 0, off)};
                    @(negedge clk);
                    done = bus.s_valid && bus.s_ready;
                    @(posedge clk);
                    #1;
                    if (ar >= 0 && bus.m_valid && int'(bus.m_tile_row) == ar && int'(bus.m_tile_col) == ac)
                        return;
                    guard++;
                    if (guard > 500) bail("feed_timeout");
                end
            end
        end
        bus.s_valid = 1'b0;
    endtask

    task automatic wait_tile(input int r, input int c);
        int guard;
        guard = 0;
        while (!(bus.m_valid && int'(bus.m_tile_row) == r && int'(bus.m_tile_col) == c)) begin
            @(posedge clk);
            #1;
            guard++;
            if (guard > 2000) bail("wait_tile_timeout");
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 500) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("drain_scoreboard_empty", sb.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard on every tile handshake and checks protocol rules.
    logic [TILE_W-1:0] held_tile;
    int  held_row, held_col;
    bit  held_last;
    bit  stalled = 1'b0, stall_seen = 1'b0, fd_pending = 1'b0, prev_valid = 1'b0;
    int  pix_cnt = 0, last_hs = 0;

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            stalled    = 1'b0;
            stall_seen = 1'b0;
            fd_pending = 1'b0;
            prev_valid = 1'b0;
            pix_cnt    = 0;
        end else begin
            check("frame_done", int'(bus.frame_done), int'(fd_pending));
            if (bus.frame_done) fd_count++;
            fd_pending = 1'b0;
            if (bus.s_valid && bus.s_ready) pix_cnt++;
            if (stalled) begin
                check("stall_m_valid", int'(bus.m_valid), 1);
                check_tile("stall_m_tile", bus.m_tile, held_tile);
                check("stall_row", int'(bus.m_tile_row), held_row);
                check("stall_col", int'(bus.m_tile_col), held_col);
                check("stall_last", int'(bus.m_last), int'(held_last));
            end
            stalled = 1'b0;
            if (bus.m_valid) begin
                check("s_ready_during_emit", int'(bus.s_ready), 0);
                if (!prev_valid) begin
                    if (sb.size() != 0) check("pixels_before_tile_row", pix_cnt, (sb[0].row == 0) ? 32 : 16);
                    pix_cnt = 0;
                end
                if (bus.m_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_tile: got row %0d col %0d, expected no tile",
                                 bus.m_tile_row, bus.m_tile_col);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        check_tile("tile_data", bus.m_tile, e.tile);
                        check("tile_row", int'(bus.m_tile_row), e.row);
                        check("tile_col", int'(bus.m_tile_col), e.col);
                        check("tile_last", int'(bus.m_last), int'(e.last));
                        if (e.col > 0 && !stall_seen) check("back_to_back_gap", cyc - last_hs, 1);
                        if (e.off == 0 && e.row == 0 && e.col == 0) begin
                            check("t00_e000", elem(bus.m_tile, 0, 0, 0), 0);
                            check("t00_e330", elem(bus.m_tile, 3, 3, 0), 27);
                            check("t00_e332", elem(bus.m_tile, 3, 3, 2), 155);
                        end
                        if (e.off == 0 && e.row == 1 && e.col == 2) begin
                            check("t12_e000", elem(bus.m_tile, 0, 0, 0), 20);
                            check("t12_e331", elem(bus.m_tile, 3, 3, 1), 111);
                        end
                        if (e.off == 1 && e.row == 0 && e.col == 0)
                            check("f2_t00_e000", elem(bus.m_tile, 0, 0, 0), 1);
                        if (e.last) fd_pending = 1'b1;
                    end
                    stall_seen = 1'b0;
                    last_hs    = cyc;
                end else begin
                    stalled    = 1'b1;
                    stall_seen = 1'b1;
                    held_tile  = bus.m_tile;
                    held_row   = int'(bus.m_tile_row);
                    held_col   = int'(bus.m_tile_col);
                    held_last  = bus.m_last;
                end
            end
            prev_valid = bus.m_valid;
        end
    end

    initial begin
        #500000;
        bail("global_watchdog");
    end

    initial begin
        reset       = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_pixel = '0;
        bus.m_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_m_valid", int'(bus.m_valid), 0);
        check("reset_s_ready", int'(bus.s_ready), 0);
        check("reset_m_last", int'(bus.m_last), 0);
        check("reset_frame_done", int'(bus.frame_done), 0);
        check_tile("reset_m_tile", bus.m_tile, '0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("idle_s_ready", int'(bus.s_ready), 1);
        @(posedge clk);
        #1;

        // Full frame, consumer always ready
        push_frame(0);
        feed_frame(0, 1'b0, -1, -1);
        drain();

        // Backpressure on tile (2,1)
        push_frame(0);
        fork
            feed_frame(0, 1'b0, -1, -1);
            begin
                wait_tile(2, 1);
                bus.m_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                bus.m_ready = 1'b1;
            end
        join
        drain();

        // Random input bubbles
        push_frame(0);
        feed_frame(0, 1'b1, -1, -1);
        drain();

        // Reset while tile (1,1) is presented, then refeed the frame
        push_frame(0);
        feed_frame(0, 1'b0, 1, 1);
        bus.m_ready = 1'b0;
        bus.s_valid = 1'b0;
        reset       = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        reset       = 1'b0;
        bus.m_ready = 1'b1;
        @(negedge clk);
        check("post_reset_m_valid", int'(bus.m_valid), 0);
        check("post_reset_s_ready", int'(bus.s_ready), 1);
        @(posedge clk);
        #1;
        push_frame(0);
        feed_frame(0, 1'b0, -1, -1);
        drain();

        // Two back-to-back frames, second with every sample +1
        push_frame(0);
        push_frame(1);
        feed_frame(0, 1'b0, -1, -1);
        feed_frame(1, 1'b0, -1, -1);
        drain();

        check("frame_done_pulses", fd_count, 6);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
